int_ctrl_sequencer: RTL and testbench

- Six-source priority interrupt controller that owns the IRR (request), IMR (mask) and ISR (in-service) registers.
- Arbitrates pending requests and hands the CPU one vector code at a time through an intr/inta handshake.
- Holds the code in service until end-of-interrupt (EOI), then clears it.
- Its code and ISR outputs drive the interrupt decoder stage that sits between the controller and the CPU.

---
 rtl/int_ctrl_pkg.sv | 24 ++
 rtl/irq_prio_enc.sv | 22 ++
 rtl/int_ctrl_sequencer.sv | 153 +++++++++++++++
 tb/tb_int_ctrl_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared types and helpers for the six-source interrupt controller
// and the decoder stage that consumes its code/ISR outputs.
package int_ctrl_pkg;

    localparam int NUM_IRQ = 6;

    localparam logic [2:0] CODE_NONE = 3'd0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    function automatic logic [2:0] line_to_code(input logic [2:0] idx);
        return idx + 3'd1;
    endfunction

    // Code n lands on ISR_out[NUM_IRQ-n], so line k maps to bit NUM_IRQ-1-k.
    function automatic logic [2:0] line_to_isr_bit(input logic [2:0] idx);
        return 3'(NUM_IRQ - 1) - idx;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-wins priority encoder over the request lines.
// Shared with the decoder-side logic.
module irq_prio_enc
    import int_ctrl_pkg::*;
(
    input  logic [NUM_IRQ-1:0] req,
    output logic [2:0]         idx,
    output logic               valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = 3'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_ctrl_sequencer.sv
// Priority interrupt controller: IRR/IMR/ISR registers, edge capture
// and the intr/inta/eoi handshake sequencer.
module int_ctrl_sequencer
    import int_ctrl_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] irq,
    input  logic       imr_wr,
    input  logic [5:0] imr_data,
    input  logic       inta,
    input  logic       eoi,
    output logic       intr,
    output logic [2:0] code_out,
    output logic [5:0] ISR_out,
    output logic [5:0] irr_out,
    output logic       timeout_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t state;
    state_t state_nxt;

    logic [NUM_IRQ-1:0] irq_d;
    logic [NUM_IRQ-1:0] rise_q;
    logic [NUM_IRQ-1:0] irr;
    logic [NUM_IRQ-1:0] imr;
    logic [NUM_IRQ-1:0] isr;
    logic [NUM_IRQ-1:0] elig;
    logic [NUM_IRQ-1:0] sel_oh;
    logic [2:0]         sel;
    logic [2:0]         win;
    logic               win_vld;
    logic [CNT_W-1:0]   cnt;

    logic grant;
    logic ack;
    logic tmo;
    logic done;
    logic cnt_inc;

    assign elig   = irr & ~imr;
    assign sel_oh = NUM_IRQ'(1) << sel;

    irq_prio_enc u_enc (
        .req   (elig),
        .idx   (win),
        .valid (win_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // inta is checked ahead of the timeout so a late ack still wins.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        ack       = 1'b0;
        tmo       = 1'b0;
        done      = 1'b0;
        cnt_inc   = 1'b0;
        unique case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nxt = REQ;
                    grant     = 1'b1;
                end
            end
            REQ: begin
                if (inta) begin
                    state_nxt = SERVICE;
                    ack       = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    tmo       = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_d       <= '0;
            rise_q      <= '0;
            irr         <= '0;
            imr         <= '1;
            isr         <= '0;
            sel         <= '0;
            cnt         <= '0;
            intr        <= 1'b0;
            code_out    <= CODE_NONE;
            timeout_err <= 1'b0;
        end else begin
            irq_d       <= irq;
            rise_q      <= irq & ~irq_d;
            timeout_err <= tmo;
            // A fresh edge on the acked line re-queues it.
            irr <= (irr & ~(ack ? sel_oh : '0)) | rise_q;
            if (imr_wr) begin
                imr <= imr_data;
            end
            if (ack) begin
                isr <= isr | sel_oh;
            end else if (done) begin
                isr <= isr & ~sel_oh;
            end
            if (grant) begin
                sel      <= win;
                code_out <= line_to_code(win);
                intr     <= 1'b1;
                cnt      <= '0;
            end else if (ack) begin
                intr <= 1'b0;
            end else if (tmo) begin
                intr     <= 1'b0;
                code_out <= CODE_NONE;
            end else if (done) begin
                code_out <= CODE_NONE;
            end
            if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        ISR_out = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            ISR_out[line_to_isr_bit(3'(i))] = isr[i];
        end
    end

    assign irr_out = irr;

endmodule

// File: tb/tb_int_ctrl_sequencer.sv
// Directed bench for int_ctrl_sequencer: vector table plus
// hand sequences for timeout, nesting-free service and reset.
module tb_int_ctrl_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] irq = '0;
    logic       imr_wr = 1'b0;
    logic [5:0] imr_data = '0;
    logic       inta = 1'b0;
    logic       eoi = 1'b0;
    logic       intr;
    logic [2:0] code_out;
    logic [5:0] ISR_out;
    logic [5:0] irr_out;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    int_ctrl_sequencer #(.ACK_TIMEOUT(16), .CNT_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq         (irq),
        .imr_wr      (imr_wr),
        .imr_data    (imr_data),
        .inta        (inta),
        .eoi         (eoi),
        .intr        (intr),
        .code_out    (code_out),
        .ISR_out     (ISR_out),
        .irr_out     (irr_out),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] irq;
        logic       wr;
        logic [5:0] data;
        logic       inta;
        logic       eoi;
        logic       intr;
        logic [2:0] code;
        logic [5:0] isr;
        logic [5:0] irr;
        logic       tmo;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(logic [5:0] q, logic w, logic [5:0] d,
                                logic a, logic e, logic i, logic [2:0] c,
                                logic [5:0] s, logic [5:0] r, logic t);
        vec_t v;
        v.irq = q; v.wr = w; v.data = d; v.inta = a; v.eoi = e;
        v.intr = i; v.code = c; v.isr = s; v.irr = r; v.tmo = t;
        return v;
    endfunction

    function automatic logic [20:0] obs();
        return {intr, code_out, ISR_out, irr_out, timeout_err};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;

        vecs[0]  = mk(6'h00, 1, 6'h00, 0, 0, 0, 0, 6'h00, 6'h00, 0);
        vecs[1]  = mk(6'h04, 0, 6'h00, 0, 0, 0, 0, 6'h00, 6'h00, 0);
        vecs[2]  = mk(6'h00, 0, 6'h00, 0, 0, 0, 0, 6'h00, 6'h04, 0);
        vecs[3]  = mk(6'h00, 0, 6'h00, 0, 0, 1, 3, 6'h00, 6'h04, 0);
        vecs[4]  = mk(6'h00, 0, 6'h00, 1, 0, 0, 3, 6'h08, 6'h00, 0);
        vecs[5]  = mk(6'h00, 0, 6'h00, 0, 0, 0, 3, 6'h08, 6'h00, 0);
        vecs[6]  = mk(6'h00, 0, 6'h00, 0, 1, 0, 0, 6'h00, 6'h00, 0);
        vecs[7]  = mk(6'h12, 0, 6'h00, 0, 0, 0, 0, 6'h00, 6'h00, 0);
        vecs[8]  = mk(6'h00, 0, 6'h00, 0, 0, 0, 0, 6'h00, 6'h12, 0);
        vecs[9]  = mk(6'h00, 0, 6'h00, 0, 0, 1, 2, 6'h00, 6'h12, 0);
        vecs[10] = mk(6'h00, 0, 6'h00, 1, 0, 0, 2, 6'h10, 6'h10, 0);
        vecs[11] = mk(6'h00, 0, 6'h00, 0, 1, 0, 0, 6'h00, 6'h10, 0);
        vecs[12] = mk(6'h00, 0, 6'h00, 0, 0, 1, 5, 6'h00, 6'h10, 0);
        vecs[13] = mk(6'h00, 0, 6'h00, 1, 0, 0, 5, 6'h02, 6'h00, 0);
        vecs[14] = mk(6'h00, 0, 6'h00, 0, 1, 0, 0, 6'h00, 6'h00, 0);
        vecs[15] = mk(6'h00, 1, 6'h02, 0, 0, 0, 0, 6'h00, 6'h00, 0);
        vecs[16] = mk(6'h02, 0, 6'h00, 0, 0, 0, 0, 6'h00, 6'h00, 0);
        vecs[17] = mk(6'h00, 0, 6'h00, 0, 0, 0, 0, 6'h00, 6'h02, 0);
        vecs[18] = mk(6'h00, 0, 6'h00, 0, 0, 0, 0, 6'h00, 6'h02, 0);
        vecs[19] = mk(6'h00, 1, 6'h00, 0, 0, 0, 0, 6'h00, 6'h02, 0);
        vecs[20] = mk(6'h00, 0, 6'h00, 0, 0, 1, 2, 6'h00, 6'h02, 0);
        vecs[21] = mk(6'h00, 0, 6'h00, 1, 0, 0, 2, 6'h10, 6'h00, 0);
        vecs[22] = mk(6'h00, 0, 6'h00, 0, 1, 0, 0, 6'h00, 6'h00, 0);
        vecs[23] = mk(6'h00, 0, 6'h00, 1, 0, 0, 0, 6'h00, 6'h00, 0);

        repeat (3) tick();
        chk("reset_state", 32'(obs()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        foreach (vecs[k]) begin
            irq = vecs[k].irq; imr_wr = vecs[k].wr; imr_data = vecs[k].data;
            inta = vecs[k].inta; eoi = vecs[k].eoi;
            tick();
            chk($sformatf("vec%0d", k), 32'(obs()),
                32'({vecs[k].intr, vecs[k].code, vecs[k].isr,
                     vecs[k].irr, vecs[k].tmo}));
        end
        imr_wr = 0; inta = 0; eoi = 0; irq = 0;

        // ack timeout on line 0
        irq = 6'h01; tick();
        irq = 6'h00; tick();
        chk("to_irr_set", 32'({intr, irr_out}), 32'h01);
        tick();
        chk("to_req", 32'({intr, code_out}), 32'h9);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!intr) break;
            n++;
        end
        chk("to_intr_cycles", 32'(n), 32'd16);
        chk("to_err_pulse", 32'(obs()), 32'({1'b0, 3'd0, 6'h00, 6'h01, 1'b1}));
        tick();
        chk("to_retry", 32'(obs()), 32'({1'b1, 3'd1, 6'h00, 6'h01, 1'b0}));
        // new edge on the acked line in the ack cycle
        irq = 6'h01; tick();
        irq = 6'h00; inta = 1; tick();
        inta = 0;
        chk("ack_edge_requeue", 32'(obs()), 32'({1'b0, 3'd1, 6'h20, 6'h01, 1'b0}));
        eoi = 1; tick();
        eoi = 0; tick();
        chk("requeued_served", 32'({intr, code_out}), 32'h9);
        inta = 1; tick();
        inta = 0; eoi = 1; tick();
        eoi = 0;
        chk("requeue_done", 32'(obs()), 32'h0);

        // request during service is held off until eoi
        irq = 6'h04; tick();
        irq = 6'h00; tick();
        tick();
        inta = 1; tick();
        inta = 0; irq = 6'h01; tick();
        irq = 6'h00; tick();
        tick();
        chk("svc_no_nest", 32'(obs()), 32'({1'b0, 3'd3, 6'h08, 6'h01, 1'b0}));
        eoi = 1; tick();
        eoi = 0;
        chk("svc_eoi", 32'({intr, code_out, ISR_out}), 32'h0);
        tick();
        chk("svc_next", 32'({intr, code_out}), 32'h9);
        inta = 1; tick();
        inta = 0; eoi = 1; tick();
        eoi = 0;

        // reset in the middle of a request, line 3 held high throughout
        irq = 6'h08; tick();
        tick();
        tick();
        chk("rst_pre_req", 32'({intr, code_out}), 32'hC);
        rst_n = 1'b0;
        #1;
        chk("rst_immediate", 32'(obs()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("rst_held_edge", 32'(irr_out), 32'h08);
        tick();
        chk("rst_imr_masked", 32'({intr, code_out}), 32'h0);
        imr_wr = 1; imr_data = 6'h00; tick();
        imr_wr = 0; tick();
        chk("rst_unmask", 32'({intr, code_out}), 32'hC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
